// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard controller for the 5-stage core. Sits beside decode and keeps a
//   small shadow record of the instructions now in EX and MEM. From these
//   records and the instruction in ID it produces:
//     - the EX-stage operand forwarding selects (registered as ID enters EX)
//     - the load-use stall (hold PC and IF/ID, bubble into ID/EX)
//     - the shared-RAM structural stall (hold PC, bubble into IF/ID)
//     - the redirect flush (bubble IF/ID and ID/EX)
//   It also keeps saturating stall and flush performance counters.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   id_valid     in   1      ID holds a real instruction
//   id_rs_a      in   REG_W  ID source A (NONE_ID if unused)
//   id_rs_b      in   REG_W  ID source B / store-data reg (NONE_ID if unused)
//   id_b_imm     in   1      ID operand B is an immediate
//   id_rd        in   REG_W  ID destination (NONE_ID if no write)
//   id_load      in   1      ID is a load
//   id_mem       in   1      ID accesses data RAM (load or store)
//   ex_redirect  in   1      EX resolved a jump / taken branch
//   fwd_a        out  2      operand A select: 00 reg, 01 ALU result, 10 WB data
//   fwd_b        out  2      operand B select, same encoding
//   fwd_w        out  2      store-data select, same encoding
//   pc_hold      out  1      PC keeps its value
//   ifid_hold    out  1      IF/ID keeps its value
//   ifid_bubble  out  1      IF/ID loads a NOP
//   idex_bubble  out  1      ID/EX loads a NOP
//   stall_cnt    out  CNT_W  cycles spent in a load-use or structural stall
//   flush_cnt    out  CNT_W  redirects taken
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int               REG_W   = 4,
  parameter logic [REG_W-1:0] NONE_ID = {REG_W{1'b1}},
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_b_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_load,
  input  logic             id_mem,
  input  logic             ex_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_w,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow records of the EX and MEM stage instructions
  logic             ex_v;
  logic [REG_W-1:0] ex_rd;
  logic             ex_load;
  logic             ex_mem;
  logic             mem_v;
  logic [REG_W-1:0] mem_rd;
  logic             mem_mem;

  logic             lu;
  logic             st;
  logic             stall_event;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic [1:0]       sel_w;

  // A load's data is not ready until it leaves MEM, so a load in EX never
  // supplies the ALU bypass; its consumer stalls and later takes the WB path.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             e_v,
    input logic             e_load,
    input logic [REG_W-1:0] e_rd,
    input logic             m_v,
    input logic [REG_W-1:0] m_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (e_v && !e_load && (e_rd != NONE_ID) && (src == e_rd)) begin
      sel = 2'b01;
    end else if (m_v && (m_rd != NONE_ID) && (src == m_rd)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Hazard detection from the current records and the ID instruction
  always_comb begin
    lu = ex_v && ex_load && (ex_rd != NONE_ID) &&
         ((ex_rd == id_rs_a) || (ex_rd == id_rs_b));
    st = mem_v && mem_mem;
    stall_event = (lu || st) && !ex_redirect;
  end

  // Pipeline control: redirect beats load-use, which beats the RAM conflict.
  // On a RAM conflict only fetch is blocked; the ID instruction still advances.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      if (ex_redirect) begin
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end else if (st) begin
        pc_hold     = 1'b1;
        ifid_bubble = 1'b1;
      end
    end
  end

  // Forwarding selects for the ID instruction, captured as it enters EX.
  // Store data always comes through source B even when B is an immediate.
  always_comb begin
    sel_a = fwd_sel(id_rs_a, ex_v, ex_load, ex_rd, mem_v, mem_rd);
    sel_w = fwd_sel(id_rs_b, ex_v, ex_load, ex_rd, mem_v, mem_rd);
    sel_b = id_b_imm ? 2'b00 : sel_w;
  end

  // Stage records, forwarding registers and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v      <= 1'b0;
      ex_rd     <= NONE_ID;
      ex_load   <= 1'b0;
      ex_mem    <= 1'b0;
      mem_v     <= 1'b0;
      mem_rd    <= NONE_ID;
      mem_mem   <= 1'b0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      fwd_w     <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem_v   <= ex_v;
      mem_rd  <= ex_rd;
      mem_mem <= ex_mem;

      if (idex_bubble || !id_valid) begin
        ex_v    <= 1'b0;
        ex_rd   <= NONE_ID;
        ex_load <= 1'b0;
        ex_mem  <= 1'b0;
        fwd_a   <= 2'b00;
        fwd_b   <= 2'b00;
        fwd_w   <= 2'b00;
      end else begin
        ex_v    <= 1'b1;
        ex_rd   <= id_rd;
        ex_load <= id_load;
        ex_mem  <= id_mem;
        fwd_a   <= sel_a;
        fwd_b   <= sel_b;
        fwd_w   <= sel_w;
      end

      if (stall_event && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (ex_redirect && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl. Each scenario task queues a
//   short instruction sequence, one row per cycle, with the outputs expected
//   in that cycle. Counters are narrowed so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int OW = 10 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [3:0]    id_rs_a;
  logic [3:0]    id_rs_b;
  logic          id_b_imm;
  logic [3:0]    id_rd;
  logic          id_load;
  logic          id_mem;
  logic          ex_redirect;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic [1:0]    fwd_w;
  logic          pc_hold;
  logic          ifid_hold;
  logic          ifid_bubble;
  logic          idex_bubble;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [OW-1:0] obs;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .NONE_ID(4'hF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_a(id_rs_a),
    .id_rs_b(id_rs_b), .id_b_imm(id_b_imm), .id_rd(id_rd),
    .id_load(id_load), .id_mem(id_mem), .ex_redirect(ex_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_w(fwd_w), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_bubble(ifid_bubble),
    .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {fwd_a, fwd_b, fwd_w, pc_hold, ifid_hold, ifid_bubble,
                idex_bubble, stall_cnt, flush_cnt};

  typedef struct packed {
    logic       v;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       bi;
    logic [3:0] rd;
    logic       ld;
    logic       mm;
  } instr_t;

  typedef struct {
    string         name;
    instr_t        i;
    logic          rdr;
    logic          r;
    logic          chk;
    logic [OW-1:0] e;
  } row_t;

  typedef struct {
    string         name;
    logic [OW-1:0] v;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [OW-1:0] pack(input logic [1:0] fa, input logic [1:0] fb,
                                         input logic [1:0] fw, input logic ph,
                                         input logic ih, input logic ib, input logic eb,
                                         input int sc, input int fc);
    return {fa, fb, fw, ph, ih, ib, eb, sc[CW-1:0], fc[CW-1:0]};
  endfunction

  function automatic instr_t mk(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                                input logic bi, input logic [3:0] rd,
                                input logic ld, input logic mm);
    instr_t t;
    t.v = v; t.ra = ra; t.rb = rb; t.bi = bi; t.rd = rd; t.ld = ld; t.mm = mm;
    return t;
  endfunction

  function automatic instr_t idle_i();
    return mk(1'b0, 4'hF, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0);
  endfunction

  function automatic instr_t alu_i(input logic [3:0] ra, input logic [3:0] rb,
                                   input logic [3:0] rd);
    return mk(1'b1, ra, rb, 1'b0, rd, 1'b0, 1'b0);
  endfunction

  function automatic instr_t lw_i(input logic [3:0] base, input logic [3:0] rd);
    return mk(1'b1, base, 4'hF, 1'b1, rd, 1'b1, 1'b1);
  endfunction

  function automatic instr_t sw_i(input logic [3:0] base, input logic [3:0] data);
    return mk(1'b1, base, data, 1'b1, 4'hF, 1'b0, 1'b1);
  endfunction

  task automatic add_row(input string name, input instr_t i, input logic rdr,
                         input logic r, input logic chk, input logic [OW-1:0] e);
    row_t row;
    row.name = name; row.i = i; row.rdr = rdr; row.r = r; row.chk = chk; row.e = e;
    rows.push_back(row);
  endtask

  task automatic drive(input instr_t i, input logic rdr, input logic r);
    id_valid    = i.v;
    id_rs_a     = i.ra;
    id_rs_b     = i.rb;
    id_b_imm    = i.bi;
    id_rd       = i.rd;
    id_load     = i.ld;
    id_mem      = i.mm;
    ex_redirect = rdr;
    rst         = r;
  endtask

  task automatic do_reset();
    drive(idle_i(), 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    row_t r;
    exp_t e;
    do_reset();
    add_row("reset_state", idle_i(), 1'b0, 1'b0, 1'b1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fwd_ex();
    row_t r;
    exp_t e;
    do_reset();
    add_row("exfwd_add_r1",   alu_i(4, 5, 1), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("exfwd_consumer", alu_i(1, 6, 2), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("exfwd_in_ex",    idle_i(),       0, 0, 1, pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("exfwd_after",    idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_fwd();
    row_t r;
    exp_t e;
    do_reset();
    add_row("store_add_r1",  alu_i(4, 5, 1), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("store_nop",     idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("store_sw_id",   sw_i(6, 1),     0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("store_sw_ex",   idle_i(),       0, 0, 1, pack(0, 0, 2, 0, 0, 0, 0, 0, 0));
    add_row("store_sw_mem",  idle_i(),       0, 0, 1, pack(0, 0, 0, 1, 0, 1, 0, 0, 0));
    add_row("store_cnt",     idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    row_t r;
    exp_t e;
    do_reset();
    add_row("lu_lw_r3",     lw_i(6, 3),     0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("lu_stall",     alu_i(3, 5, 4), 0, 0, 1, pack(0, 0, 0, 1, 1, 0, 1, 0, 0));
    add_row("lu_lw_in_mem", alu_i(3, 5, 4), 0, 0, 1, pack(0, 0, 0, 1, 0, 1, 0, 1, 0));
    add_row("lu_cons_ex",   idle_i(),       0, 0, 1, pack(2, 0, 0, 0, 0, 0, 0, 2, 0));
    add_row("lu_after",     idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 2, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_struct_stall();
    row_t r;
    exp_t e;
    do_reset();
    add_row("st_lw",        lw_i(6, 3),     0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("st_unrelated", alu_i(4, 5, 6), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("st_lw_in_mem", idle_i(),       0, 0, 1, pack(0, 0, 0, 1, 0, 1, 0, 0, 0));
    add_row("st_cnt",       idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fwd_select();
    row_t r;
    exp_t e;
    do_reset();
    // EX match beats MEM match on all three selects
    add_row("prio_add1",    alu_i(4, 5, 1), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("prio_add1b",   alu_i(4, 5, 1), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("prio_cons",    alu_i(1, 1, 2), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("prio_in_ex",   idle_i(),       0, 0, 1, pack(1, 1, 1, 0, 0, 0, 0, 0, 0));
    // immediate operand B suppresses fwd_b but not store-data forwarding
    add_row("imm_add1",     alu_i(4, 5, 1), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("imm_cons",     mk(1, 4, 1, 1, 2, 0, 0), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("imm_in_ex",    idle_i(),       0, 0, 1, pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // NONE_ID never matches as a destination
    add_row("none_add",     alu_i(4, 5, 4'hF), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("none_load",    mk(1, 4'hF, 4'hF, 0, 4'hF, 1, 0), 0, 0, 1,
            pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("none_nolu",    alu_i(4'hF, 4'hF, 2), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("none_in_ex",   idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    row_t r;
    exp_t e;
    do_reset();
    add_row("rdr_lw",       lw_i(6, 3),     0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("rdr_over_lu",  alu_i(3, 5, 4), 1, 0, 1, pack(0, 0, 0, 0, 0, 1, 1, 0, 0));
    add_row("rdr_lw_mem",   idle_i(),       0, 0, 1, pack(0, 0, 0, 1, 0, 1, 0, 0, 1));
    add_row("rdr_cnts",     idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 1, 1));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    row_t r;
    exp_t e;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      add_row($sformatf("b2b_rdr%0d", k), idle_i(), 1, 0, 1,
              pack(0, 0, 0, 0, 0, 1, 1, 0, k));
    end
    add_row("b2b_cnt", idle_i(), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 3));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    row_t r;
    exp_t e;
    int   sat;
    sat = (1 << CW) - 1;
    do_reset();
    // back-to-back RAM accesses: every cycle from the third on is a stall
    for (int k = 0; k < 20; k++) begin
      add_row($sformatf("sat_st%0d", k), mk(1, 4'hF, 4'hF, 1, 4'hF, 0, 1), 0, 0, 1,
              pack(0, 0, 0, k >= 2, 0, k >= 2, 0, (k < 2) ? 0 : ((k - 2 > sat) ? sat : k - 2), 0));
    end
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
    do_reset();
    for (int k = 0; k < 19; k++) begin
      add_row($sformatf("sat_fl%0d", k), idle_i(), 1, 0, 1,
              pack(0, 0, 0, 0, 0, 1, 1, 0, (k > sat) ? sat : k));
    end
    add_row("sat_fl_end", idle_i(), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, sat));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t r;
    exp_t e;
    do_reset();
    add_row("rst_lw",       lw_i(6, 3),     0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("rst_lu",       alu_i(3, 5, 4), 0, 0, 1, pack(0, 0, 0, 1, 1, 0, 1, 0, 0));
    add_row("rst_st",       alu_i(3, 5, 4), 0, 0, 1, pack(0, 0, 0, 1, 0, 1, 0, 1, 0));
    add_row("rst_lw2",      lw_i(6, 7),     0, 0, 1, pack(2, 0, 0, 0, 0, 0, 0, 2, 0));
    add_row("rst_assert",   alu_i(7, 5, 4), 0, 1, 0, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("rst_cleared",  alu_i(7, 5, 4), 0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_row("rst_no_stall", idle_i(),       0, 0, 1, pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
    while (rows.size() != 0) begin
      r = rows.pop_front();
      drive(r.i, r.rdr, r.r);
      if (r.chk) sb.push_back('{r.name, r.e});
      #2;
      if (r.chk) begin
        e = sb.pop_front();
        tests++;
        if (obs !== e.v) begin
          fails++;
          $display("[TB] FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    drive(idle_i(), 1'b0, 1'b1);
    @(negedge clk);
    test_reset();
    test_fwd_ex();
    test_store_fwd();
    test_load_use();
    test_struct_stall();
    test_fwd_select();
    test_redirect();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
